// File: rtl/jtag_scan_driver.sv
// JTAG scan-stimulus and capture engine: drives a programmable-length pattern on TDI,
// captures TDO on the same edges and reports a masked compare against an expected value.
module jtag_scan_driver #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               TCK,
  input  logic               reset,
  input  logic               load,
  input  logic [MAX_LEN-1:0] scan_pattern,
  input  logic [MAX_LEN-1:0] expected,
  input  logic [MAX_LEN-1:0] mask,
  input  logic [LEN_W-1:0]   shift_len,
  input  logic               msb_first,
  input  logic               fill_bit,
  input  logic               enable_shift,
  input  logic               abort,
  input  logic               from_TDO,
  output logic               to_TDI,
  output logic               busy,
  output logic               done,
  output logic               mismatch,
  output logic [MAX_LEN-1:0] captured,
  output logic [LEN_W-1:0]   bits_left
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  logic [1:0]         state;
  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] exp_q;
  logic [MAX_LEN-1:0] mask_q;
  logic               msb_q;
  logic [LEN_W-1:0]   len_q;

  logic [LEN_W-1:0]   load_len;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   cap_idx;
  logic [MAX_LEN-1:0] cap_next;
  logic               mm_next;
  logic               accept;
  logic               advance;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    load_len = (shift_len > MAX_L) ? MAX_L : shift_len;
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(load_len));

    // Position of the bit being driven now, expressed through the remaining-shift count.
    cap_idx  = msb_q ? (bits_left - LEN_W'(1)) : (len_q - bits_left);
    cap_next = captured;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) == cap_idx) cap_next[i] = from_TDO;
    end
    // Bits at or above L are excluded by the mask trimmed at load time.
    mm_next = |((cap_next ^ exp_q) & mask_q);

    accept  = (state == S_IDLE) && load && (shift_len != '0);
    advance = (state == S_SHIFT) && enable_shift && !abort;

    to_TDI = fill_bit;
    if (state == S_SHIFT) to_TDI = msb_q ? pat_q[MAX_LEN-1] : pat_q[0];
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge TCK) begin
    if (reset) begin
      state     <= S_IDLE;
      captured  <= '0;
      bits_left <= '0;
      mismatch  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_SHIFT;
            bits_left <= load_len;
            captured  <= '0;
            mismatch  <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (enable_shift) begin
            captured  <= cap_next;
            bits_left <= bits_left - LEN_W'(1);
            if (bits_left == LEN_W'(1)) begin
              state    <= S_DONE;
              mismatch <= mm_next;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the scan payload registers carry no reset; they are always written on an
  // accepted load before anything reads them, so resetting them buys nothing.
  always_ff @(posedge TCK) begin
    if (accept) begin
      // MSB-first patterns are left-aligned so the outgoing bit is always the top bit.
      pat_q  <= msb_first ? (scan_pattern << (MAX_LEN - int'(load_len))) : scan_pattern;
      exp_q  <= expected;
      mask_q <= mask & len_mask;
      msb_q  <= msb_first;
      len_q  <= load_len;
    end else if (advance) begin
      pat_q <= msb_q ? {pat_q[MAX_LEN-2:0], fill_bit} : {fill_bit, pat_q[MAX_LEN-1:1]};
    end
  end

endmodule

// File: tb/tb_jtag_scan_driver.sv
// Self-checking bench for jtag_scan_driver: directed table, hand-written corner
// sequences and randomized scans checked against a bit-index reference model.
module tb_jtag_scan_driver;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic               TCK = 1'b0;
  logic               reset;
  logic               load;
  logic [MAX_LEN-1:0] scan_pattern;
  logic [MAX_LEN-1:0] expected;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   shift_len;
  logic               msb_first;
  logic               fill_bit;
  logic               enable_shift;
  logic               abort;
  logic               from_TDO;
  logic               to_TDI;
  logic               busy;
  logic               done;
  logic               mismatch;
  logic [MAX_LEN-1:0] captured;
  logic [LEN_W-1:0]   bits_left;

  jtag_scan_driver #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .TCK(TCK), .reset(reset), .load(load), .scan_pattern(scan_pattern),
    .expected(expected), .mask(mask), .shift_len(shift_len), .msb_first(msb_first),
    .fill_bit(fill_bit), .enable_shift(enable_shift), .abort(abort),
    .from_TDO(from_TDO), .to_TDI(to_TDI), .busy(busy), .done(done),
    .mismatch(mismatch), .captured(captured), .bits_left(bits_left)
  );

  always #5 TCK = ~TCK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // tdo_mode: 0 loopback, 1 tied high, 2 tied low, 3 random.
  // en_mode:  0 always enabled, 1 random stalls, 2 repeating 1,0,0 pattern.
  typedef struct {
    logic [31:0] pat;
    logic [31:0] exp_v;
    logic [31:0] msk;
    logic [5:0]  len;
    logic        msb;
    logic        fill;
    int          tdo_mode;
    int          en_mode;
    logic [31:0] want_cap;
    logic        want_mm;
  } vec_t;

  task automatic run_scan(input vec_t v, output logic [31:0] m_cap, output logic m_mm);
    int          l;
    int          k;
    int          guard;
    int          idx;
    logic        b;
    logic        en;
    logic        tdo;
    logic [31:0] lm;
    l     = (int'(v.len) > MAX_LEN) ? MAX_LEN : int'(v.len);
    k     = 0;
    guard = 0;
    m_cap = '0;
    @(negedge TCK);
    scan_pattern = v.pat; expected = v.exp_v; mask = v.msk; shift_len = v.len;
    msb_first = v.msb; fill_bit = v.fill; load = 1'b1; enable_shift = 1'b0;
    @(negedge TCK);
    load = 1'b0;
    check("busy_after_load", busy, 1);
    check("bits_left_init", bits_left, l);
    check("captured_cleared", captured, 0);
    while (k < l) begin
      guard++;
      if (guard > 4 * l + 20) begin
        check("shift_timeout", k, l);
        break;
      end
      idx = v.msb ? (l - 1 - k) : k;
      b   = v.pat[idx];
      check("to_tdi", to_TDI, b);
      check("bits_left", bits_left, l - k);
      check("done_low_in_shift", done, 0);
      case (v.en_mode)
        0:       en = 1'b1;
        1:       en = ($urandom_range(0, 2) != 0);
        default: en = (((guard - 1) % 3) == 0);
      endcase
      case (v.tdo_mode)
        0:       tdo = b;
        1:       tdo = 1'b1;
        2:       tdo = 1'b0;
        default: tdo = 1'($urandom_range(0, 1));
      endcase
      // A load request during a stall must be ignored while busy.
      load = !en && (v.en_mode != 0);
      if (load) shift_len = 6'd5;
      enable_shift = en;
      from_TDO     = tdo;
      if (en) begin
        m_cap[idx] = tdo;
        k++;
      end
      @(negedge TCK);
    end
    load = 1'b0;
    enable_shift = 1'b0;
    lm   = (l == 32) ? 32'hFFFF_FFFF : ((32'd1 << l) - 32'd1);
    m_mm = |((m_cap ^ v.exp_v) & v.msk & lm);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 1);
    check("to_tdi_fill_in_done", to_TDI, v.fill);
    check("mismatch_at_done", mismatch, m_mm);
    check("captured_at_done", captured, m_cap);
    @(negedge TCK);
    check("done_one_cycle", done, 0);
    check("busy_back_idle", busy, 0);
    check("mismatch_held", mismatch, m_mm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[6];
    vec_t        rv;
    logic [31:0] m_cap;
    logic        m_mm;
    logic [31:0] part;

    reset = 1'b1; load = 1'b0; scan_pattern = '0; expected = '0; mask = '0;
    shift_len = '0; msb_first = 1'b0; fill_bit = 1'b1; enable_shift = 1'b0;
    abort = 1'b0; from_TDO = 1'b0;
    repeat (2) @(negedge TCK);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_captured", captured, 0);
    check("rst_bits_left", bits_left, 0);
    check("rst_tdi_fill1", to_TDI, 1);
    fill_bit = 1'b0;
    #1;
    check("idle_tdi_fill0", to_TDI, 0);

    //            pat           exp           mask          len    msb   fill  tdo en  cap           mm
    tbl[0] = '{32'h0000_00A5, 32'h0000_00A5, 32'h0000_00FF, 6'd8,  1'b0, 1'b0, 0, 0, 32'h0000_00A5, 1'b0};
    tbl[1] = '{32'h0000_00A5, 32'h0000_00FE, 32'h0000_00FE, 6'd8,  1'b1, 1'b1, 1, 0, 32'h0000_00FF, 1'b0};
    tbl[2] = '{32'h0000_00A5, 32'h0000_00FE, 32'h0000_00FF, 6'd8,  1'b1, 1'b0, 1, 0, 32'h0000_00FF, 1'b1};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd63, 1'b0, 1'b0, 1, 0, 32'hFFFF_FFFF, 1'b0};
    tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd32, 1'b1, 1'b0, 0, 0, 32'hFFFF_FFFF, 1'b0};
    tbl[5] = '{32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 6'd3,  1'b0, 1'b1, 0, 0, 32'h0000_0005, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_scan(tbl[i], m_cap, m_mm);
      check($sformatf("tbl%0d_captured", i), captured, tbl[i].want_cap);
      check($sformatf("tbl%0d_mismatch", i), mismatch, tbl[i].want_mm);
    end

    // Stall pattern 1,0,0,1,... with ignored load pulses, L=4 loopback.
    rv = '{32'h0000_000B, 32'h0000_000B, 32'h0000_000F, 6'd4, 1'b0, 1'b1, 0, 2, 32'h0000_000B, 1'b0};
    run_scan(rv, m_cap, m_mm);
    check("stall_captured", captured, 32'h0000_000B);
    check("stall_mismatch", mismatch, 0);

    // Zero-length load is ignored; the previous capture survives.
    @(negedge TCK);
    shift_len = 6'd0; load = 1'b1;
    @(negedge TCK);
    load = 1'b0;
    check("len0_busy", busy, 0);
    check("len0_done", done, 0);
    check("len0_captured_kept", captured, 32'h0000_000B);
    @(negedge TCK);
    check("len0_no_done_later", done, 0);

    // Abort after 3 of 10 shifts.
    scan_pattern = 32'h0000_03A5; expected = '0; mask = '1; shift_len = 6'd10;
    msb_first = 1'b0; fill_bit = 1'b0; load = 1'b1;
    @(negedge TCK);
    load = 1'b0;
    part = '0;
    for (int i = 0; i < 3; i++) begin
      check("abort_tdi", to_TDI, scan_pattern[i]);
      from_TDO = 1'($urandom_range(0, 1));
      part[i] = from_TDO;
      enable_shift = 1'b1;
      @(negedge TCK);
    end
    abort = 1'b1;
    enable_shift = 1'b1;
    @(negedge TCK);
    abort = 1'b0;
    enable_shift = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_captured", captured, part);
    check("abort_mismatch", mismatch, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge TCK);
      check("abort_no_late_done", done, 0);
    end

    // Randomized scans against the reference model.
    for (int i = 0; i < 24; i++) begin
      rv.pat      = $urandom;
      rv.len      = 6'($urandom_range(1, 40));
      rv.msb      = 1'($urandom_range(0, 1));
      rv.fill     = 1'($urandom_range(0, 1));
      rv.en_mode  = 1;
      rv.want_cap = '0;
      rv.want_mm  = 1'b0;
      if (i % 2 == 0) begin
        rv.exp_v = rv.pat; rv.msk = $urandom; rv.tdo_mode = 0;
      end else begin
        rv.exp_v = $urandom; rv.msk = $urandom; rv.tdo_mode = 3;
      end
      run_scan(rv, m_cap, m_mm);
      check("rand_captured", captured, m_cap);
      check("rand_mismatch", mismatch, m_mm);
    end

    // Reset in the middle of a scan.
    @(negedge TCK);
    scan_pattern = 32'h0000_00FF; expected = '0; mask = '1; shift_len = 6'd8;
    msb_first = 1'b0; fill_bit = 1'b1; load = 1'b1;
    @(negedge TCK);
    load = 1'b0; from_TDO = 1'b1; enable_shift = 1'b1;
    repeat (2) @(negedge TCK);
    reset = 1'b1;
    repeat (2) @(negedge TCK);
    reset = 1'b0; enable_shift = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_mismatch", mismatch, 0);
    check("midrst_captured", captured, 0);
    check("midrst_bits_left", bits_left, 0);
    check("midrst_tdi_fill", to_TDI, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
